// File: rtl/uart_byte_tx.sv
// UART byte transmitter: serializes upstream bytes onto txd, LSB first,
// with optional parity and 1 or 2 stop bits. A one-byte holding register
// lets the next byte be accepted while the current one is shifting, so
// consecutive bytes go out with no idle bit between them.
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Reject unsupported configurations at elaboration
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_byte_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end

  logic [2:0]        state_q, state_n;
  logic [7:0]        shift_q, shift_n;
  logic [7:0]        hold_q, hold_n;
  logic              hold_full_q, hold_full_n;
  logic              par_q, par_n;
  logic [2:0]        bit_q, bit_n;
  logic [BAUD_W-1:0] baud_q, baud_n;
  logic              txd_q, txd_n;
  logic              accept;
  logic              bit_end;

  // Parity bit for a byte, captured when the byte enters the shifter
  function automatic logic par_of(input logic [7:0] b);
    return (PARITY == 2) ? ~^b : ^b;
  endfunction

  assign in_ready = !hold_full_q;
  assign busy     = (state_q != S_IDLE) || hold_full_q;
  assign txd      = txd_q;
  assign accept   = in_valid && !hold_full_q;
  assign bit_end  = (baud_q == BAUD_LAST);

  // State and datapath registers; reset discards any in-flight byte
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      bit_q       <= '0;
      baud_q      <= '0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_n;
      shift_q     <= shift_n;
      hold_q      <= hold_n;
      hold_full_q <= hold_full_n;
      par_q       <= par_n;
      bit_q       <= bit_n;
      baud_q      <= baud_n;
      txd_q       <= txd_n;
    end
  end

  // Next-state, shifter/holding control and the next line level
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    par_n       = par_q;
    bit_n       = bit_q;
    baud_n      = baud_q;
    txd_n       = 1'b1;

    if (state_q != S_IDLE) begin
      baud_n = bit_end ? '0 : baud_q + BAUD_W'(1);
      if (accept) begin
        hold_n      = in_byte;
        hold_full_n = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (hold_full_q) begin
          shift_n     = hold_q;
          par_n       = par_of(hold_q);
          hold_full_n = 1'b0;
          state_n     = S_START;
        end else if (accept) begin
          shift_n = in_byte;
          par_n   = par_of(in_byte);
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_n   = '0;
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_n = '0;
            if (hold_full_q) begin
              shift_n     = hold_q;
              par_n       = par_of(hold_q);
              hold_full_n = 1'b0;
              state_n     = S_START;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    case (state_n)
      S_START:  txd_n = 1'b0;
      S_DATA:   txd_n = shift_n[0];
      S_PARITY: txd_n = par_n;
      default:  txd_n = 1'b1;
    endcase
  end

endmodule
